// File: rtl/debounce2ch.sv
// debounce2ch: two independent synchronize-and-debounce channels producing clean levels and edge pulses
module debounce2ch_ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    state_t state;
    logic [CNT_WIDTH-1:0] cnt;
    logic s1, s;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s     <= 1'b0;
            state <= STABLE_LO;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s    <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            case (state)
                STABLE_LO: if (s) begin
                    state <= WAIT_HI;
                    cnt   <= '0;
                end
                WAIT_HI: if (!s) state <= STABLE_LO;
                else if (cnt == LAST) begin
                    state <= STABLE_HI;
                    level <= 1'b1;
                    rise  <= 1'b1;
                end else cnt <= cnt + 1'b1;
                STABLE_HI: if (!s) begin
                    state <= WAIT_LO;
                    cnt   <= '0;
                end
                WAIT_LO: if (s) state <= STABLE_HI;
                else if (cnt == LAST) begin
                    state <= STABLE_LO;
                    level <= 1'b0;
                    fall  <= 1'b1;
                end else cnt <= cnt + 1'b1;
                default: state <= STABLE_LO;
            endcase
        end
    end
endmodule

module debounce2ch #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);
    debounce2ch_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_a (
        .clk(clk), .rst(rst), .raw(a_raw), .level(a), .rise(a_rise), .fall(a_fall)
    );
    debounce2ch_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_WIDTH(CNT_WIDTH)) u_b (
        .clk(clk), .rst(rst), .raw(b_raw), .level(b), .rise(b_rise), .fall(b_fall)
    );
endmodule

// File: tb/tb_debounce2ch.sv
// tb_debounce2ch: scoreboard bench; expected output vectors {a,b,a_rise,a_fall,b_rise,b_fall} are queued as stimulus is driven
module tb_debounce2ch;
    logic clk = 1'b0;
    logic rst, a_raw, b_raw;
    logic a, b, a_rise, a_fall, b_rise, b_fall;
    int n_checks = 0;
    int n_fail = 0;
    typedef struct { logic [5:0] v; int cyc; } exp_t;
    exp_t sb[$];
    exp_t e;
    logic [5:0] obs;

    debounce2ch #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .a_raw(a_raw), .b_raw(b_raw),
        .a(a), .b(b), .a_rise(a_rise), .a_fall(a_fall), .b_rise(b_rise), .b_fall(b_fall)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] pk(input logic ea, eb, ear, eaf, ebr, ebf);
        return {ea, eb, ear, eaf, ebr, ebf};
    endfunction

    // Inputs are driven 1 time unit after an edge, so the next edge captures them.
    task automatic test_reset;
        for (int k = 0; k < 8; k++) begin
            a_raw = 1'b1; b_raw = 1'b1;
            sb.push_back('{pk(k >= 6, k >= 6, k == 6, 1'b0, k == 6, 1'b0), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL reset_pre cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
        end
        #3 rst = 1'b1;
        sb.push_back('{6'b0, -1});
        #1;
        e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL reset_async: got %b expected %b", obs, e.v); end
        sb.push_back('{6'b0, 0});
        @(posedge clk); #1;
        e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL reset_held: got %b expected %b", obs, e.v); end
        #3 rst = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            a_raw = (k <= 10); b_raw = (k <= 10);
            sb.push_back('{pk(k >= 7 && k < 17, k >= 7 && k < 17, k == 7, k == 17, k == 7, k == 17), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL reset_release cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
        end
    endtask

    task automatic test_clean;
        for (int k = 0; k < 30; k++) begin
            a_raw = (k < 20); b_raw = 1'b0;
            sb.push_back('{pk(k >= 6 && k < 26, 1'b0, k == 6, k == 26, 1'b0, 1'b0), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL clean cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
        end
    endtask

    task automatic test_glitch;
        logic q[$];
        int p;
        for (int w = 1; w <= 4; w++) begin
            repeat (w) q.push_back(1'b1);
            repeat (10) q.push_back(1'b0);
        end
        p = q.size();
        repeat (5) q.push_back(1'b1);
        repeat (12) q.push_back(1'b0);
        for (int k = 0; k < q.size(); k++) begin
            a_raw = q[k]; b_raw = 1'b0;
            sb.push_back('{pk(k >= p + 6 && k < p + 11, 1'b0, k == p + 6, k == p + 11, 1'b0, 1'b0), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL glitch cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
        end
    endtask

    task automatic test_bounce;
        for (int k = 0; k < 30; k++) begin
            a_raw = (k < 8) ? k[0] : (k < 20); b_raw = 1'b0;
            sb.push_back('{pk(k >= 13 && k < 26, 1'b0, k == 13, k == 26, 1'b0, 1'b0), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL bounce cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
        end
    endtask

    task automatic test_simultaneous;
        for (int k = 0; k < 35; k++) begin
            a_raw = (k < 25); b_raw = (k < 12);
            sb.push_back('{pk(k >= 6 && k < 31, k >= 6 && k < 18, k == 6, k == 31, k == 6, k == 18), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL simultaneous cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
        end
    endtask

    // A short reset pulse lands while channel A is counting; requalification restarts at edge 4.
    task automatic test_reset_mid;
        for (int k = 0; k < 24; k++) begin
            a_raw = (k < 14); b_raw = 1'b0;
            sb.push_back('{pk(k >= 10 && k < 20, 1'b0, k == 10, k == 20, 1'b0, 1'b0), k});
            @(posedge clk); #1;
            e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
            if (obs !== e.v) begin n_fail++; $display("FAIL reset_mid cyc %0d: got %b expected %b", e.cyc, obs, e.v); end
            if (k == 3) begin
                #2 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; a_raw = 1'b0; b_raw = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{6'b0, 0});
        e = sb.pop_front(); obs = {a, b, a_rise, a_fall, b_rise, b_fall}; n_checks++;
        if (obs !== e.v) begin n_fail++; $display("FAIL power_on_reset: got %b expected %b", obs, e.v); end
        rst = 1'b0;
        test_reset();
        test_clean();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d leftover expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
